// File: rtl/mult_ctrl_taint_seq_if.sv
// Handshake and datapath-strobe bundle for the shift-add multiplier controller.
// master = environment/datapath side, slave = the controller itself.
interface mult_ctrl_taint_seq_if #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
);
    // start handshake
    logic             start;
    logic             start_t;
    logic             signed_mode;
    logic             signed_mode_t;
    logic             start_ready;
    logic             start_ready_t;
    // multiplier register view from the datapath
    logic [WIDTH-1:0] multiplierReg;
    logic [WIDTH-1:0] multiplierReg_t;
    // result handshake
    logic             product_valid;
    logic             product_valid_t;
    logic             product_ready;
    logic             product_ready_t;
    // datapath strobes and their taint companions
    logic             mdld;
    logic             mrld;
    logic             rsclear;
    logic             rsload;
    logic             rssub;
    logic             rsshr;
    logic             mdld_t;
    logic             mrld_t;
    logic             rsclear_t;
    logic             rsload_t;
    logic             rssub_t;
    logic             rsshr_t;
    logic [CW-1:0]    bit_idx;

    modport master (
        output start, start_t, signed_mode, signed_mode_t,
        output multiplierReg, multiplierReg_t,
        output product_ready, product_ready_t,
        input  start_ready, start_ready_t, product_valid, product_valid_t,
        input  mdld, mrld, rsclear, rsload, rssub, rsshr,
        input  mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t,
        input  bit_idx
    );

    modport slave (
        input  start, start_t, signed_mode, signed_mode_t,
        input  multiplierReg, multiplierReg_t,
        input  product_ready, product_ready_t,
        output start_ready, start_ready_t, product_valid, product_valid_t,
        output mdld, mrld, rsclear, rsload, rssub, rsshr,
        output mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t,
        output bit_idx
    );
endinterface

// File: rtl/mult_ctrl_taint_seq.sv
// Control FSM for a shift-add sequential multiplier with single-bit control-taint
// tracking. State is a phase plus a multiplier bit index; every strobe output
// carries the same taint bit, which records whether any tainted input has
// influenced the control flow since the last accepted start.
module mult_ctrl_taint_seq #(
    parameter int WIDTH      = 4,
    parameter int EARLY_EXIT = 1,
    parameter int CW         = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_ctrl_taint_seq_if.slave bus
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_EVAL  = 3'd2,
        PH_ADD   = 3'd3,
        PH_SHIFT = 3'd4,
        PH_FLUSH = 3'd5,
        PH_DONE  = 3'd6
    } phase_e;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    phase_e        r_phase;
    phase_e        w_phase_next;
    logic [CW-1:0] r_bit_idx;
    logic [CW-1:0] w_bit_idx_next;
    logic          r_ctrl_t;
    logic          w_ctrl_t_next;
    logic          r_signed;
    logic          w_signed_next;

    logic             w_last_bit;
    logic             w_cur_bit;
    logic             w_cur_taint;
    logic [WIDTH-1:0] w_above_mask;
    logic             w_upper_zero;
    logic             w_upper_taint;

    logic w_mdld;
    logic w_mrld;
    logic w_rsclear;
    logic w_rsload;
    logic w_rssub;
    logic w_rsshr;
    logic w_product_valid;
    logic w_start_ready;

    // Mask of multiplier bits strictly above the current bit index; used to
    // decide whether the remaining bits are all zero (early exit).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_above
            localparam logic [CW:0] BIT_POS = (CW + 1)'(gi);
            assign w_above_mask[gi] = (BIT_POS > {1'b0, r_bit_idx});
        end
    endgenerate

    assign w_last_bit    = (r_bit_idx == LAST_IDX);
    assign w_cur_bit     = bus.multiplierReg[r_bit_idx];
    assign w_cur_taint   = bus.multiplierReg_t[r_bit_idx];
    assign w_upper_zero  = ~|(bus.multiplierReg & w_above_mask);
    assign w_upper_taint = |(bus.multiplierReg_t & w_above_mask);

    // State register: phase, bit index, control taint and latched sign mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase   <= PH_IDLE;
            r_bit_idx <= '0;
            r_ctrl_t  <= 1'b0;
            r_signed  <= 1'b0;
        end else begin
            r_phase   <= w_phase_next;
            r_bit_idx <= w_bit_idx_next;
            r_ctrl_t  <= w_ctrl_t_next;
            r_signed  <= w_signed_next;
        end
    end

    // Next-state logic: phase sequencing, bit-index stepping and taint merging.
    always_comb begin
        w_phase_next   = r_phase;
        w_bit_idx_next = r_bit_idx;
        w_ctrl_t_next  = r_ctrl_t;
        w_signed_next  = r_signed;
        case (r_phase)
            PH_IDLE: begin
                if (bus.start) begin
                    // A new operation starts with a fresh taint history.
                    w_phase_next  = PH_INIT;
                    w_signed_next = bus.signed_mode;
                    w_ctrl_t_next = bus.start_t | bus.signed_mode_t;
                end else begin
                    // Waiting on a tainted start line still leaks timing.
                    w_ctrl_t_next = r_ctrl_t | bus.start_t;
                end
            end
            PH_INIT: begin
                w_bit_idx_next = '0;
                w_phase_next   = PH_EVAL;
            end
            PH_EVAL: begin
                w_ctrl_t_next = r_ctrl_t | w_cur_taint;
                w_phase_next  = w_cur_bit ? PH_ADD : PH_SHIFT;
            end
            PH_ADD: begin
                w_phase_next = PH_SHIFT;
            end
            PH_SHIFT: begin
                if (w_last_bit) begin
                    w_phase_next = PH_DONE;
                end else begin
                    w_bit_idx_next = r_bit_idx + CW'(1);
                    if (EARLY_EXIT != 0) begin
                        // The exit decision looks at every upper bit.
                        w_ctrl_t_next = r_ctrl_t | w_upper_taint;
                        w_phase_next  = w_upper_zero ? PH_FLUSH : PH_EVAL;
                    end else begin
                        w_phase_next = PH_EVAL;
                    end
                end
            end
            PH_FLUSH: begin
                if (w_last_bit) begin
                    w_phase_next = PH_DONE;
                end else begin
                    w_bit_idx_next = r_bit_idx + CW'(1);
                end
            end
            PH_DONE: begin
                // start is deliberately not looked at here, even with product_ready.
                w_ctrl_t_next = r_ctrl_t | bus.product_ready_t;
                if (bus.product_ready) begin
                    w_phase_next = PH_IDLE;
                end
            end
            default: begin
                w_phase_next = PH_IDLE;
            end
        endcase
    end

    // Output decode: Moore strobes from the current phase.
    always_comb begin
        w_mdld          = 1'b0;
        w_mrld          = 1'b0;
        w_rsclear       = 1'b0;
        w_rsload        = 1'b0;
        w_rssub         = 1'b0;
        w_rsshr         = 1'b0;
        w_product_valid = 1'b0;
        w_start_ready   = 1'b0;
        case (r_phase)
            PH_IDLE: w_start_ready = 1'b1;
            PH_INIT: begin
                w_mdld    = 1'b1;
                w_mrld    = 1'b1;
                w_rsclear = 1'b1;
            end
            PH_ADD: begin
                // The sign bit of a two's-complement multiplier has negative weight.
                if (r_signed && w_last_bit) begin
                    w_rssub = 1'b1;
                end else begin
                    w_rsload = 1'b1;
                end
            end
            PH_SHIFT, PH_FLUSH: w_rsshr = 1'b1;
            PH_DONE: w_product_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign bus.mdld          = w_mdld;
    assign bus.mrld          = w_mrld;
    assign bus.rsclear       = w_rsclear;
    assign bus.rsload        = w_rsload;
    assign bus.rssub         = w_rssub;
    assign bus.rsshr         = w_rsshr;
    assign bus.product_valid = w_product_valid;
    assign bus.start_ready   = w_start_ready;
    assign bus.bit_idx       = r_bit_idx;

    // Every taint output mirrors the control-taint register, asserted strobe or not.
    assign bus.mdld_t          = r_ctrl_t;
    assign bus.mrld_t          = r_ctrl_t;
    assign bus.rsclear_t       = r_ctrl_t;
    assign bus.rsload_t        = r_ctrl_t;
    assign bus.rssub_t         = r_ctrl_t;
    assign bus.rsshr_t         = r_ctrl_t;
    assign bus.product_valid_t = r_ctrl_t;
    assign bus.start_ready_t   = r_ctrl_t;

endmodule

// File: tb/tb_mult_ctrl_taint_seq.sv
// Bench for mult_ctrl_taint_seq: two instances (EARLY_EXIT=0 and 1) share the
// multiplier inputs; each has its own handshake lines. Expected per-cycle
// behaviour is derived from the multiplier bits as a list of operation steps.
module tb_mult_ctrl_taint_seq;
    localparam int W  = 4;
    localparam int CW = $clog2(W);
    localparam int MAXC = 64;

    localparam logic [7:0] S_MDLD = 8'h80, S_MRLD = 8'h40, S_RSCLR = 8'h20, S_LOAD = 8'h10;
    localparam logic [7:0] S_SUB  = 8'h08, S_SHR  = 8'h04, S_PV    = 8'h02, S_SR   = 8'h01;

    typedef struct packed {
        logic [7:0]    s;
        logic          t;
        logic          idx_chk;
        logic [CW-1:0] idx;
        logic          d_start;
        logic          d_start_t;
        logic          d_pr;
        logic          d_prt;
    } ent_t;

    typedef struct packed {
        logic [7:0]    s;
        logic [7:0]    t;
        logic [CW-1:0] idx;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   st, stt, pr, prt;
    logic         signed_mode, signed_mode_t;
    logic [W-1:0] mr, mt;

    ent_t sch [2][MAXC];
    obs_t obs [2][MAXC];
    int   len [2];
    int   total = 0;
    int   bad   = 0;

    mult_ctrl_taint_seq_if #(.WIDTH(W)) if0 ();
    mult_ctrl_taint_seq_if #(.WIDTH(W)) if1 ();

    assign if0.start = st[0];           assign if1.start = st[1];
    assign if0.start_t = stt[0];        assign if1.start_t = stt[1];
    assign if0.product_ready = pr[0];   assign if1.product_ready = pr[1];
    assign if0.product_ready_t = prt[0]; assign if1.product_ready_t = prt[1];
    assign if0.signed_mode = signed_mode;     assign if1.signed_mode = signed_mode;
    assign if0.signed_mode_t = signed_mode_t; assign if1.signed_mode_t = signed_mode_t;
    assign if0.multiplierReg = mr;      assign if1.multiplierReg = mr;
    assign if0.multiplierReg_t = mt;    assign if1.multiplierReg_t = mt;

    mult_ctrl_taint_seq #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mult_ctrl_taint_seq #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.s = {if0.mdld, if0.mrld, if0.rsclear, if0.rsload, if0.rssub, if0.rsshr, if0.product_valid, if0.start_ready};
            o.t = {if0.mdld_t, if0.mrld_t, if0.rsclear_t, if0.rsload_t, if0.rssub_t, if0.rsshr_t, if0.product_valid_t, if0.start_ready_t};
            o.idx = if0.bit_idx;
        end else begin
            o.s = {if1.mdld, if1.mrld, if1.rsclear, if1.rsload, if1.rssub, if1.rsshr, if1.product_valid, if1.start_ready};
            o.t = {if1.mdld_t, if1.mrld_t, if1.rsclear_t, if1.rsload_t, if1.rssub_t, if1.rsshr_t, if1.product_valid_t, if1.start_ready_t};
            o.idx = if1.bit_idx;
        end
        return o;
    endfunction

    function automatic void put(input int d, input logic [7:0] s, input logic t, input int idx,
                                input logic ds, input logic dst, input logic dp, input logic dpt);
        ent_t e;
        e.s = s; e.t = t;
        e.idx_chk = (idx >= 0);
        e.idx = (idx >= 0) ? CW'(idx) : '0;
        e.d_start = ds; e.d_start_t = dst; e.d_pr = dp; e.d_prt = dpt;
        if (len[d] < MAXC) begin
            sch[d][len[d]] = e;
            len[d]++;
        end
    endfunction

    // Expected cycle list for one operation: INIT, per-bit EVAL/[ADD]/SHIFT,
    // optional FLUSH tail, DONE (with hold), then two IDLE cycles.
    task automatic build(input int d, input logic [W-1:0] m, input logic [W-1:0] mtt, input logic sg,
                         input logic t0, input int hold, input logic fs, input logic fst, input logic fprt);
        logic t;
        bit   ee;
        ee = (d == 1);
        t = t0;
        len[d] = 0;
        put(d, S_MDLD | S_MRLD | S_RSCLR, t, -1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) begin
            put(d, 8'h00, t, i, 0, 0, 0, 0);
            t = t | mtt[i];
            if (m[i]) put(d, (sg && i == W - 1) ? S_SUB : S_LOAD, t, i, 0, 0, 0, 0);
            put(d, S_SHR, t, i, 0, 0, 0, 0);
            if (ee && i < W - 1) begin
                t = t | (|(mtt >> (i + 1)));
                if ((m >> (i + 1)) == '0) begin
                    for (int j = i + 1; j < W; j++) put(d, S_SHR, t, j, 0, 0, 0, 0);
                    break;
                end
            end
        end
        for (int h = 0; h < hold; h++) put(d, S_PV, t, W - 1, 0, 0, 0, 0);
        put(d, S_PV, t, W - 1, fs, fst, 1, fprt);
        t = t | fprt;
        put(d, S_SR, t, W - 1, 0, 0, 0, 0);
        put(d, S_SR, t, W - 1, 0, 0, 0, 0);
    endtask

    // Accept a start on both instances, then replay the expected handshake
    // drive and record what each instance shows every cycle.
    task automatic run_op(input logic sg, input logic smt, input logic st_t_in);
        int n;
        signed_mode = sg; signed_mode_t = smt;
        st = 2'b11; stt = {2{st_t_in}}; pr = 2'b00; prt = 2'b00;
        @(posedge clk); #1;
        n = (len[0] > len[1]) ? len[0] : len[1];
        for (int c = 0; c < n; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (c < len[d]) begin
                    obs[d][c] = sample(d);
                    st[d] = sch[d][c].d_start; stt[d] = sch[d][c].d_start_t;
                    pr[d] = sch[d][c].d_pr;    prt[d] = sch[d][c].d_prt;
                end else begin
                    st[d] = 1'b0; stt[d] = 1'b0; pr[d] = 1'b0; prt[d] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end
        st = 2'b00; stt = 2'b00; pr = 2'b00; prt = 2'b00;
    endtask

    task automatic test_reset();
        obs_t o;
        for (int k = 0; k < 3; k++) begin
            st = 2'($urandom); stt = 2'($urandom); pr = 2'($urandom); prt = 2'($urandom);
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                o = sample(d);
                total++;
                if (o.s !== S_SR || o.t !== 8'h00 || o.idx !== '0) begin
                    bad++;
                    $display("FAIL reset dut%0d: got s=%b t=%b idx=%0d want s=%b t=0 idx=0", d, o.s, o.t, o.idx, S_SR);
                end
            end
        end
        rst_n = 1'b1; st = 2'b00; stt = 2'b00; pr = 2'b00; prt = 2'b00;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            o = sample(d);
            total++;
            if (o.s !== S_SR || o.t !== 8'h00) begin
                bad++;
                $display("FAIL reset_release dut%0d: got s=%b t=%b want s=%b t=0", d, o.s, o.t, S_SR);
            end
        end
        $display("reset: done");
    endtask

    task automatic test_unsigned();
        int first, want, n_shr, n_ld;
        mr = 4'b0101; mt = '0;
        build(0, mr, mt, 1'b0, 1'b0, 0, 0, 0, 0);
        build(1, mr, mt, 1'b0, 1'b0, 0, 0, 0, 0);
        run_op(1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) for (int c = 0; c < len[d]; c++) begin
            total++;
            if (obs[d][c].s !== sch[d][c].s || obs[d][c].t !== {8{sch[d][c].t}} ||
                (sch[d][c].idx_chk && obs[d][c].idx !== sch[d][c].idx)) begin
                bad++;
                $display("FAIL unsigned dut%0d cycle %0d: got s=%b t=%b idx=%0d want s=%b t=%b idx=%0d",
                         d, c + 1, obs[d][c].s, obs[d][c].t, obs[d][c].idx, sch[d][c].s, {8{sch[d][c].t}}, sch[d][c].idx);
            end
        end
        for (int d = 0; d < 2; d++) begin
            first = -1;
            for (int c = 0; c < len[d]; c++) if (first < 0 && obs[d][c].s[1]) first = c + 1;
            want = (d == 0) ? (2 + 2 * W + $countones(mr)) : 11;
            total++;
            if (first !== want) begin
                bad++;
                $display("FAIL latency dut%0d: got DONE at cycle %0d want %0d", d, first, want);
            end
        end
        n_shr = 0; n_ld = 0;
        for (int c = 0; c < len[0]; c++) begin
            if (obs[0][c].s[2]) n_shr++;
            if (obs[0][c].s[4]) n_ld++;
        end
        total += 2;
        if (n_shr != 4) begin bad++; $display("FAIL rsshr_count: got %0d want 4", n_shr); end
        if (n_ld != 2)  begin bad++; $display("FAIL rsload_count: got %0d want 2", n_ld); end
        total += 2;
        if (obs[0][2].s !== S_LOAD) begin bad++; $display("FAIL add_cycle3: got s=%b want %b", obs[0][2].s, S_LOAD); end
        if (obs[0][7].s !== S_LOAD) begin bad++; $display("FAIL add_cycle8: got s=%b want %b", obs[0][7].s, S_LOAD); end
        $display("unsigned 0101: done");
    endtask

    task automatic test_signed();
        int n_sub3, n_ld3, n_ld0;
        mr = 4'b1001; mt = '0;
        build(0, mr, mt, 1'b1, 1'b0, 0, 0, 0, 0);
        build(1, mr, mt, 1'b1, 1'b0, 0, 0, 0, 0);
        run_op(1'b1, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) for (int c = 0; c < len[d]; c++) begin
            total++;
            if (obs[d][c].s !== sch[d][c].s || obs[d][c].t !== {8{sch[d][c].t}} ||
                (sch[d][c].idx_chk && obs[d][c].idx !== sch[d][c].idx)) begin
                bad++;
                $display("FAIL signed dut%0d cycle %0d: got s=%b t=%b idx=%0d want s=%b t=%b idx=%0d",
                         d, c + 1, obs[d][c].s, obs[d][c].t, obs[d][c].idx, sch[d][c].s, {8{sch[d][c].t}}, sch[d][c].idx);
            end
        end
        n_sub3 = 0; n_ld3 = 0; n_ld0 = 0;
        for (int c = 0; c < len[0]; c++) begin
            if (obs[0][c].s[3] && obs[0][c].idx == CW'(3)) n_sub3++;
            if (obs[0][c].s[4] && obs[0][c].idx == CW'(3)) n_ld3++;
            if (obs[0][c].s[4] && obs[0][c].idx == CW'(0)) n_ld0++;
        end
        total += 3;
        if (n_sub3 != 1) begin bad++; $display("FAIL rssub_bit3: got %0d want 1", n_sub3); end
        if (n_ld3 != 0)  begin bad++; $display("FAIL rsload_bit3: got %0d want 0", n_ld3); end
        if (n_ld0 != 1)  begin bad++; $display("FAIL rsload_bit0: got %0d want 1", n_ld0); end
        $display("signed 1001: done");
    endtask

    task automatic test_taint();
        int ce;
        mr = 4'b0101; mt = 4'b0100;
        build(0, mr, mt, 1'b0, 1'b0, 0, 0, 0, 0);
        build(1, mr, mt, 1'b0, 1'b0, 0, 0, 0, 0);
        run_op(1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) for (int c = 0; c < len[d]; c++) begin
            total++;
            if (obs[d][c].s !== sch[d][c].s || obs[d][c].t !== {8{sch[d][c].t}} ||
                (sch[d][c].idx_chk && obs[d][c].idx !== sch[d][c].idx)) begin
                bad++;
                $display("FAIL taint dut%0d cycle %0d: got s=%b t=%b idx=%0d want s=%b t=%b idx=%0d",
                         d, c + 1, obs[d][c].s, obs[d][c].t, obs[d][c].idx, sch[d][c].s, {8{sch[d][c].t}}, sch[d][c].idx);
            end
        end
        ce = -1;
        for (int c = 1; c < len[0] - 1; c++) if (ce < 0 && obs[0][c].s == 8'h00 && obs[0][c].idx == CW'(2)) ce = c;
        total += 3;
        if (ce < 0 || obs[0][ce].t !== 8'h00) begin bad++; $display("FAIL taint_eval2: got cycle %0d want taint 0 in EVAL bit 2", ce + 1); end
        if (ce < 0 || obs[0][ce + 1].t !== 8'hFF) begin bad++; $display("FAIL taint_after_eval2: got cycle %0d want taint 1 after EVAL bit 2", ce + 2); end
        if (obs[0][len[0] - 1].t !== 8'hFF) begin bad++; $display("FAIL taint_idle: got t=%b want 11111111", obs[0][len[0] - 1].t); end
        $display("taint 0100: done");
    endtask

    task automatic test_idle_taint();
        obs_t o;
        st = 2'b00; stt = 2'b11;
        @(posedge clk); #1;
        stt = 2'b00;
        for (int d = 0; d < 2; d++) begin
            o = sample(d);
            total++;
            if (o.s !== S_SR || o.t !== 8'hFF) begin
                bad++;
                $display("FAIL idle_taint dut%0d: got s=%b t=%b want s=%b t=11111111", d, o.s, o.t, S_SR);
            end
        end
        mr = W'($urandom); mt = '0;
        build(0, mr, mt, 1'b0, 1'b0, 0, 0, 0, 0);
        build(1, mr, mt, 1'b0, 1'b0, 0, 0, 0, 0);
        run_op(1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs[d][0].s !== (S_MDLD | S_MRLD | S_RSCLR) || obs[d][0].t !== 8'h00) begin
                bad++;
                $display("FAIL taint_reload dut%0d: got s=%b t=%b want s=%b t=0", d, obs[d][0].s, obs[d][0].t, S_MDLD | S_MRLD | S_RSCLR);
            end
        end
        $display("idle taint reload: done");
    endtask

    task automatic test_backpressure();
        mr = 4'b0110; mt = '0;
        build(0, mr, mt, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0);
        build(1, mr, mt, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0);
        run_op(1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) for (int c = 0; c < len[d]; c++) begin
            total++;
            if (obs[d][c].s !== sch[d][c].s || obs[d][c].t !== {8{sch[d][c].t}} ||
                (sch[d][c].idx_chk && obs[d][c].idx !== sch[d][c].idx)) begin
                bad++;
                $display("FAIL backpressure dut%0d cycle %0d: got s=%b t=%b idx=%0d want s=%b t=%b idx=%0d",
                         d, c + 1, obs[d][c].s, obs[d][c].t, obs[d][c].idx, sch[d][c].s, {8{sch[d][c].t}}, sch[d][c].idx);
            end
        end
        $display("backpressure hold 5 + start with ready: done");
    endtask

    task automatic test_reset_mid();
        obs_t o;
        mr = 4'b0001; mt = '0;
        signed_mode = 1'b0; signed_mode_t = 1'b0;
        st = 2'b11; stt = 2'b11;
        @(posedge clk); #1;
        st = 2'b00; stt = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            o = sample(d);
            total++;
            if (o.s !== S_LOAD || o.t !== 8'hFF) begin
                bad++;
                $display("FAIL mid_add dut%0d: got s=%b t=%b want s=%b t=11111111", d, o.s, o.t, S_LOAD);
            end
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            o = sample(d);
            total++;
            if (o.s !== S_SR || o.t !== 8'h00 || o.idx !== '0) begin
                bad++;
                $display("FAIL mid_reset dut%0d: got s=%b t=%b idx=%0d want s=%b t=0 idx=0", d, o.s, o.t, o.idx, S_SR);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            o = sample(d);
            total++;
            if (o.s !== S_SR) begin
                bad++;
                $display("FAIL mid_reset_idle dut%0d: got s=%b want %b", d, o.s, S_SR);
            end
        end
        $display("reset during ADD: done");
    endtask

    task automatic test_random();
        logic sg, smt, sttv, fs, fst, fprt;
        int   hold;
        for (int k = 0; k < 30; k++) begin
            mr   = W'($urandom);
            mt   = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            sg   = 1'($urandom);
            smt  = ($urandom_range(0, 7) == 0);
            sttv = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(0, 3);
            fs   = 1'($urandom);
            fst  = 1'($urandom);
            fprt = ($urandom_range(0, 5) == 0);
            build(0, mr, mt, sg, sttv | smt, hold, fs, fst, fprt);
            build(1, mr, mt, sg, sttv | smt, hold, fs, fst, fprt);
            run_op(sg, smt, sttv);
            for (int d = 0; d < 2; d++) for (int c = 0; c < len[d]; c++) begin
                total++;
                if (obs[d][c].s !== sch[d][c].s || obs[d][c].t !== {8{sch[d][c].t}} ||
                    (sch[d][c].idx_chk && obs[d][c].idx !== sch[d][c].idx)) begin
                    bad++;
                    $display("FAIL random op%0d dut%0d cycle %0d: got s=%b t=%b idx=%0d want s=%b t=%b idx=%0d",
                             k, d, c + 1, obs[d][c].s, obs[d][c].t, obs[d][c].idx, sch[d][c].s, {8{sch[d][c].t}}, sch[d][c].idx);
                end
            end
            $display("random op%0d: mr=%b mt=%b signed=%0d hold=%0d", k, mr, mt, sg, hold);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        st = 2'b00; stt = 2'b00; pr = 2'b00; prt = 2'b00;
        signed_mode = 1'b0; signed_mode_t = 1'b0;
        mr = '0; mt = '0;
        len[0] = 0; len[1] = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_taint();
        test_idle_taint();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_ctrl_taint_seq.md
Name: mult_ctrl_taint_seq

Overview:
- Parametrised control FSM for the shift-add sequential multiplier, with single-bit state-taint tracking.
- Successor to the fixed-width bitwise controller; state is encoded as a phase plus a bit-index counter.
- Adds a start/ready handshake, a held-result valid/ready handshake, signed (two's-complement) mode and optional early exit.
- Drives datapath load/clear/shift/subtract strobes. Every strobe has a taint companion derived from a control-taint register.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 2.
- EARLY_EXIT, 1, when 1, skip evaluation of remaining multiplier bits once all of them are zero.
- CW, $clog2(WIDTH), bit-index counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request to begin a multiply
- start_t  in  1  taint of start
- signed_mode  in  1  1 = two's-complement operands, sampled with start
- signed_mode_t  in  1  taint of signed_mode
- start_ready  out  1  high only in IDLE
- multiplierReg  in  WIDTH  multiplier register contents from the datapath
- multiplierReg_t  in  WIDTH  per-bit taint of multiplierReg
- product_valid  out  1  result available; held until accepted
- product_ready  in  1  consumer accepts the result
- product_ready_t  in  1  taint of product_ready
- mdld, mrld, rsclear, rsload, rssub, rsshr  out  1 each  datapath strobes
- mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t, product_valid_t, start_ready_t  out  1 each  taint outputs
- bit_idx  out  CW  current multiplier bit index

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- While rst_n=0 at a clk edge:
  - phase=IDLE, bit_idx=0, ctrl_t=0, mode register=0.
  - All strobes, product_valid and all taint outputs are 0.
- Reset mid-operation aborts unconditionally at the next edge; no DONE is produced.
- Phases: IDLE, INIT, EVAL, ADD, SHIFT, FLUSH, DONE. Transitions:
  - IDLE: start=1 -> INIT; latch signed_mode; ctrl_t <= start_t|signed_mode_t. start=0 -> stay; ctrl_t <= ctrl_t|start_t.
  - INIT: assert mdld, mrld, rsclear; bit_idx<=0 -> EVAL.
  - EVAL: multiplierReg[bit_idx]=1 -> ADD, else -> SHIFT. ctrl_t |= multiplierReg_t[bit_idx].
  - ADD: assert rssub if signed mode and bit_idx=WIDTH-1, otherwise rsload -> SHIFT.
  - SHIFT: assert rsshr.
    - bit_idx=WIDTH-1 -> DONE.
    - Else, if EARLY_EXIT and multiplierReg[WIDTH-1:bit_idx+1]==0 -> FLUSH.
    - Else -> EVAL.
    - bit_idx increments on leaving SHIFT to EVAL or FLUSH.
    - With EARLY_EXIT=1 and bit_idx<WIDTH-1: ctrl_t |= |multiplierReg_t[WIDTH-1:bit_idx+1].
  - FLUSH: assert rsshr each cycle. bit_idx=WIDTH-1 -> DONE, else bit_idx++.
  - DONE: assert product_valid. product_ready=1 -> IDLE, else hold. ctrl_t |= product_ready_t.
- Handshake rules:
  - start is ignored outside IDLE; start_t is not merged outside IDLE.
  - start and product_ready high together in DONE: go to IDLE only; start is not accepted that cycle.
  - The result stays valid indefinitely under backpressure.
- Taint:
  - Every taint output equals ctrl_t in every non-reset cycle, whether or not its strobe is asserted.
  - ctrl_t is cleared only by reset or by a start acceptance in IDLE, where it is reloaded as above.
- Exactly one of rsload/rssub/rsshr is high per cycle, or none.
- Latency (no early exit), counted from the start-accept edge:
  - DONE is entered after 2 + 2*WIDTH + popcount(multiplier) cycles.
  - Each FLUSH bit saves 1 cycle, plus 1 more if that bit would have been a 1 (impossible by definition).

Test Plan:
- WIDTH=4, EARLY_EXIT=0, unsigned, multiplierReg=4'b0101, accept start at edge 0:
  - INIT at cycle 1; ADD at cycles 3 and 8; DONE (product_valid=1) at cycle 12.
  - 4 rsshr pulses, 2 rsload pulses, all taints 0.
- Same operands with EARLY_EXIT=1: FLUSH at cycle 10, DONE at cycle 11.
- Signed, multiplierReg=4'b1001: rsload at bit 0, rssub at bit 3, rsload never at bit 3.
- multiplierReg_t=4'b0100, untainted start: all taint outputs 0 until EVAL of bit 2, then 1 through DONE; start_ready_t stays 1 in the following IDLE.
- Hold product_ready=0 for 5 cycles in DONE: product_valid stays 1. Then assert product_ready together with start: IDLE next cycle, start not accepted.
- Drop rst_n=0 for one cycle during ADD: all outputs and ctrl_t are 0 next cycle, phase=IDLE, start_ready=1.
